// File: rtl/if_stage_pc_unit.sv
// Fetch-stage front end: program counter, next-PC select, misalignment trap and the
// IF/ID pipeline register that feeds decode.
module if_stage_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned PC_STEP     = 4,
    parameter int unsigned FLUSH_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             pc_sel,
    input  logic [31:0]            branch_target,
    input  logic [31:0]            jalr_target,
    input  logic [31:0]            jal_target,
    input  logic                   flush_if_id,
    input  logic                   stall,
    input  logic [31:0]            imem_instr,
    output logic [31:0]            pc,
    output logic [31:0]            if_id_pc,
    output logic [31:0]            if_id_instr,
    output logic                   if_id_valid,
    output logic                   misalign_trap,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {StBoot, StRun, StTrap} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            if_id_pc_q, if_id_pc_d;
    logic [31:0]            if_id_instr_q, if_id_instr_d;
    logic                   if_id_valid_q, if_id_valid_d;
    logic                   trap_q, trap_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] target;
    logic        redirect;
    logic        misalign;

    always_comb begin
        target = pc_q + 32'(PC_STEP);
        unique case (pc_sel)
            2'b00:   target = branch_target;
            2'b01:   target = {jalr_target[31:1], 1'b0};
            2'b10:   target = jal_target;
            default: target = pc_q + 32'(PC_STEP);
        endcase
    end

    assign redirect = (pc_sel != 2'b11);
    // Bit 0 of a JALR target is already cleared, so only bit 1 can be misaligned.
    assign misalign = redirect && target[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
            trap_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            trap_q        <= trap_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = misalign ? StTrap : StRun;
            StTrap:  state_d = StTrap;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        trap_d        = trap_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            StRun: begin
                // A redirect beats stall; a misaligned one freezes pc and traps.
                if (redirect) begin
                    if (misalign) begin
                        trap_d = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end else if (!stall) begin
                    pc_d = target;
                end

                if (flush_if_id) begin
                    if_id_pc_d    = '0;
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                end else if (!stall) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_instr;
                    if_id_valid_d = 1'b1;
                end

                if (flush_if_id && (cnt_q != '1)) begin
                    cnt_d = cnt_q + FLUSH_CNT_W'(1);
                end
            end
            StTrap: begin
                if_id_pc_d    = '0;
                if_id_instr_d = '0;
                if_id_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign pc            = pc_q;
    assign if_id_pc      = if_id_pc_q;
    assign if_id_instr   = if_id_instr_q;
    assign if_id_valid   = if_id_valid_q;
    assign misalign_trap = trap_q;
    assign flush_count   = cnt_q;

endmodule

// File: tb/tb_if_stage_pc_unit.sv
// Scoreboard bench for if_stage_pc_unit: the driver queues the expected post-edge state,
// a monitor pops and compares one entry after every rising edge.
module tb_if_stage_pc_unit;

    typedef struct packed {
        logic [3:0]  m;      // check mask: 0 pc, 1 IF/ID, 2 trap, 3 flush_count
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        v;
        logic        trap;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [3:0] ALL = 4'hF;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pc_sel;
    logic [31:0] branch_target, jalr_target, jal_target, imem_instr;
    logic        flush_if_id, stall;
    logic [31:0] pc, if_id_pc, if_id_instr;
    logic        if_id_valid, misalign_trap;
    logic [15:0] flush_count;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    if_stage_pc_unit #(
        .RESET_PC   (32'h0000_0000),
        .PC_STEP    (4),
        .FLUSH_CNT_W(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_sel       (pc_sel),
        .branch_target(branch_target),
        .jalr_target  (jalr_target),
        .jal_target   (jal_target),
        .flush_if_id  (flush_if_id),
        .stall        (stall),
        .imem_instr   (imem_instr),
        .pc           (pc),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .misalign_trap(misalign_trap),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %h, want %h", nm, fld, act, req);
        end
    endtask

    // Monitor: every rising edge produces one output state to score.
    always @(posedge clk) begin
        exp_t  e;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.m[0]) chk(nm, "pc", pc, e.pc);
            if (e.m[1]) begin
                chk(nm, "if_id_pc", if_id_pc, e.ipc);
                chk(nm, "if_id_instr", if_id_instr, e.instr);
                chk(nm, "if_id_valid", 32'(if_id_valid), 32'(e.v));
            end
            if (e.m[2]) chk(nm, "misalign_trap", 32'(misalign_trap), 32'(e.trap));
            if (e.m[3]) chk(nm, "flush_count", 32'(flush_count), 32'(e.cnt));
        end
    end

    task automatic drv(input logic [1:0] sel, input logic fl, input logic st,
                       input logic [31:0] ins);
        pc_sel      = sel;
        flush_if_id = fl;
        stall       = st;
        imem_instr  = ins;
    endtask

    // Queue the state expected after the next rising edge, then move to the next falling edge.
    task automatic step(input string nm, input logic [3:0] m, input logic [31:0] e_pc,
                        input logic [31:0] e_ipc, input logic [31:0] e_instr, input logic e_v,
                        input logic e_trap, input logic [15:0] e_cnt);
        exp_t e;
        e = '{m: m, pc: e_pc, ipc: e_ipc, instr: e_instr, v: e_v, trap: e_trap, cnt: e_cnt};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        branch_target = '0;
        jalr_target = '0;
        jal_target = '0;
        drv(2'b11, 1'b0, 1'b0, 32'h0000_0013);
        @(negedge clk);

        step("rst0", ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        step("rst1", ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        // BOOT ignores redirect, flush and stall.
        reset = 1'b1;
        branch_target = 32'h80;
        drv(2'b00, 1'b1, 1'b1, 32'h0000_0013);
        step("boot", ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        drv(2'b11, 1'b0, 1'b0, 32'h0000_0013);
        step("run0", ALL, 32'h4, 32'h0, 32'h13, 1'b1, 1'b0, 16'd0);
        drv(2'b11, 1'b0, 1'b0, 32'h0010_0093);
        step("run4", ALL, 32'h8, 32'h4, 32'h0010_0093, 1'b1, 1'b0, 16'd0);

        branch_target = 32'h40;
        drv(2'b00, 1'b1, 1'b0, 32'h0000_dead);
        step("br_flush", ALL, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 16'd1);
        drv(2'b11, 1'b0, 1'b0, 32'h11);
        step("br_tgt", ALL, 32'h44, 32'h40, 32'h11, 1'b1, 1'b0, 16'd1);

        for (int i = 0; i < 3; i++) begin
            drv(2'b11, 1'b0, 1'b1, 32'h22);
            step("stall_hold", ALL, 32'h44, 32'h40, 32'h11, 1'b1, 1'b0, 16'd1);
        end
        jal_target = 32'h100;
        drv(2'b10, 1'b0, 1'b1, 32'h22);
        step("jal_over_stall", ALL, 32'h100, 32'h40, 32'h11, 1'b1, 1'b0, 16'd1);
        drv(2'b11, 1'b0, 1'b0, 32'h33);
        step("jal_tgt", ALL, 32'h104, 32'h100, 32'h33, 1'b1, 1'b0, 16'd1);
        drv(2'b11, 1'b1, 1'b1, 32'h34);
        step("flush_and_stall", ALL, 32'h104, 32'h0, 32'h0, 1'b0, 1'b0, 16'd2);
        drv(2'b11, 1'b0, 1'b0, 32'h44);
        step("resume", ALL, 32'h108, 32'h104, 32'h44, 1'b1, 1'b0, 16'd2);
        jal_target = 32'h200;
        drv(2'b10, 1'b0, 1'b0, 32'h55);
        step("redir_no_flush", ALL, 32'h200, 32'h108, 32'h55, 1'b1, 1'b0, 16'd2);

        jalr_target = 32'h201;
        drv(2'b01, 1'b1, 1'b0, 32'h66);
        step("jalr_mask", ALL, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, 16'd3);
        drv(2'b11, 1'b0, 1'b0, 32'h77);
        step("jalr_tgt", ALL, 32'h204, 32'h200, 32'h77, 1'b1, 1'b0, 16'd3);

        branch_target = 32'hFFFF_FFFC;
        drv(2'b00, 1'b1, 1'b0, 32'h78);
        step("br_top", ALL, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 16'd4);
        drv(2'b11, 1'b0, 1'b0, 32'h88);
        step("wrap", ALL, 32'h0, 32'hFFFF_FFFC, 32'h88, 1'b1, 1'b0, 16'd4);
        drv(2'b11, 1'b0, 1'b0, 32'h99);
        step("after_wrap", ALL, 32'h4, 32'h0, 32'h99, 1'b1, 1'b0, 16'd4);

        jalr_target = 32'h202;
        drv(2'b01, 1'b1, 1'b0, 32'h9a);
        step("misalign", ALL, 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 16'd5);
        branch_target = 32'h40;
        drv(2'b00, 1'b1, 1'b0, 32'haa);
        step("trap_redir", ALL, 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 16'd5);
        drv(2'b11, 1'b0, 1'b0, 32'hbb);
        step("trap_seq", ALL, 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 16'd5);

        reset = 1'b0;
        step("rst_trap", ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        reset = 1'b1;
        step("boot2", ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        drv(2'b11, 1'b0, 1'b0, 32'h13);
        step("run2", ALL, 32'h4, 32'h0, 32'h13, 1'b1, 1'b0, 16'd0);

        drv(2'b11, 1'b1, 1'b0, 32'h13);
        for (int i = 1; i <= 65538; i++) begin
            step("sat", (i >= 65534) ? 4'b1010 : 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                 (i >= 65535) ? 16'hFFFF : 16'(i));
        end
        drv(2'b11, 1'b0, 1'b0, 32'h13);
        step("sat_hold", ALL, 32'h0004_0010, 32'h0004_000C, 32'h13, 1'b1, 1'b0, 16'hFFFF);

        @(posedge clk);
        #2;
        chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
